// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 movement decoder.
//   - scancode constants for the prefix bytes and the keys of interest
//   - dir_t: game-core direction encoding
//   - ps2_state_t: prefix-tracking FSM states
//   - map_arrow(): scancode to direction lookup for the extended arrow keys
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        DIR_BOTTOMLEFT  = 2'd0,
        DIR_BOTTOMRIGHT = 2'd1,
        DIR_TOPLEFT     = 2'd2,
        DIR_TOPRIGHT    = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } dir_map_t;

    // The game board is isometric, so each arrow maps to a diagonal.
    function automatic dir_map_t map_arrow(input logic [7:0] sc);
        dir_map_t m;
        m.hit = 1'b1;
        m.dir = DIR_BOTTOMLEFT;
        case (sc)
            SC_UP:    m.dir = DIR_TOPLEFT;
            SC_LEFT:  m.dir = DIR_BOTTOMLEFT;
            SC_DOWN:  m.dir = DIR_BOTTOMRIGHT;
            SC_RIGHT: m.dir = DIR_TOPRIGHT;
            default:  m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: small synchronous FIFO for queued movement commands.
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   push, push_data  - write request and data
//   pop              - read request; ignored while empty
//   pop_data         - head entry, forced to 0 while empty
//   full, empty      - occupancy flags
//   overflow         - one-cycle pulse when a push is dropped
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder: turns the PS/2 scancode stream into queued movement
// commands and an activate pulse for the game core.
// Ports:
//   clock, reset                    - system clock, synchronous active-high reset
//   received_data, received_data_en - scancode byte and its one-cycle strobe
//   cmd_ready                       - game core takes the head command
//   cmd_valid, cmd_dir              - head of the command queue
//   activate                        - one-cycle pulse on a space make
//   overflow                        - one-cycle pulse when a command is dropped
//   held_valid                      - a direction key is currently held
// Build option: define PS2_KEY_REPEAT_EN to add internal auto-repeat of the
// held direction (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for a prefix, or a plain make (space)
// ST_EXT     | E0 seen; next byte is an extended make or F0
// ST_BRK     | F0 seen; next byte is a plain break, ignored
// ST_EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_move_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_dir,
    output logic       activate,
    output logic       overflow,
    output logic       held_valid
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ps2_move_decoder: FIFO_DEPTH must be a power of two >= 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("ps2_move_decoder: REPEAT_DELAY must be >= 2, REPEAT_PERIOD >= 1");
    end

    ps2_state_t state_q, state_d;
    dir_map_t   amap;
    logic       make_hit;
    logic       brk_hit;
    logic       activate_d;
    logic       activate_q;
    logic       held_valid_q;
    dir_t       held_dir_q;
    logic       make_new;
    logic       brk_match;
    logic       push;
    dir_t       push_dir;
    logic       fifo_empty;
    logic       fifo_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        make_hit   = 1'b0;
        brk_hit    = 1'b0;
        activate_d = 1'b0;
        amap       = map_arrow(received_data);
        if (received_data_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (received_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (received_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (received_data == SC_SPACE) begin
                        activate_d = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (received_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d  = ST_IDLE;
                        make_hit = amap.hit;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    brk_hit = amap.hit;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A make of the direction already held is a keyboard typematic repeat.
    assign make_new  = make_hit && !(held_valid_q && (held_dir_q == amap.dir));
    assign brk_match = brk_hit && held_valid_q && (held_dir_q == amap.dir);

    always_ff @(posedge clock) begin
        if (reset) begin
            held_valid_q <= 1'b0;
            held_dir_q   <= DIR_BOTTOMLEFT;
            activate_q   <= 1'b0;
        end else begin
            activate_q <= activate_d;
            if (make_new) begin
                held_valid_q <= 1'b1;
                held_dir_q   <= amap.dir;
            end else if (brk_match) begin
                held_valid_q <= 1'b0;
            end
        end
    end

`ifdef PS2_KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    // The make cycle itself and the terminal-count cycle both count toward
    // the delay, hence the load of DELAY-2 so the first repeat lands exactly
    // REPEAT_DELAY cycles after the make strobe.
    localparam logic [RPT_W-1:0] RPT_LOAD_DELAY  = RPT_W'(REPEAT_DELAY - 2);
    localparam logic [RPT_W-1:0] RPT_LOAD_PERIOD = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_fire;

    // A break arriving on the expiry cycle suppresses that last repeat.
    assign rpt_fire = held_valid_q && (rpt_cnt_q == '0) && !brk_match;

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_cnt_q <= '0;
        end else if (make_new) begin
            rpt_cnt_q <= RPT_LOAD_DELAY;
        end else if (!held_valid_q || brk_match) begin
            rpt_cnt_q <= '0;
        end else if (rpt_cnt_q == '0) begin
            rpt_cnt_q <= RPT_LOAD_PERIOD;
        end else begin
            rpt_cnt_q <= rpt_cnt_q - RPT_W'(1);
        end
    end

    // A fresh make takes priority over a coinciding repeat expiry.
    assign push     = make_new || rpt_fire;
    assign push_dir = make_new ? amap.dir : held_dir_q;
`else
    assign push     = make_new;
    assign push_dir = amap.dir;
`endif

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_dir),
        .pop       (cmd_ready),
        .pop_data  (cmd_dir),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign cmd_valid  = !fifo_empty;
    assign activate   = activate_q;
    assign held_valid = held_valid_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb_ps2_move_decoder: directed self-checking bench for ps2_move_decoder.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ps2_move_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       activate;
    logic       overflow;
    logic       held_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_move_decoder #(
        .FIFO_DEPTH    (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .clock            (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .cmd_ready        (cmd_ready),
        .cmd_valid        (cmd_valid),
        .cmd_dir          (cmd_dir),
        .activate         (activate),
        .overflow         (overflow),
        .held_valid       (held_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        @(negedge CLOCK_50);
        cmd_ready = 1'b0;
    endtask

    task automatic drain_expect(input string tag, input logic [1:0] d0, input logic [1:0] d1,
                                input logic [1:0] d2, input logic [1:0] d3);
        logic [1:0] exp_d [4];
        exp_d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(cmd_valid), 1);
            check($sformatf("%s_dir%0d", tag, i), 32'(cmd_dir), 32'(exp_d[i]));
            pop_one();
        end
        check($sformatf("%s_empty", tag), 32'(cmd_valid), 0);
    endtask

    initial begin
        @(negedge CLOCK_50);
        do_reset();

        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_dir", 32'(cmd_dir), 0);
        check("rst_activate", 32'(activate), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_held", 32'(held_valid), 0);

        // Up arrow: topleft
        strobe(8'hE0);
        strobe(8'h75);
        check("up_valid", 32'(cmd_valid), 1);
        check("up_dir", 32'(cmd_dir), 2);
        check("up_held", 32'(held_valid), 1);
        pop_one();
        check("up_popped", 32'(cmd_valid), 0);

        // Left arrow with a typematic repeat, then its break
        strobe(8'hE0);
        strobe(8'h6B);
        check("left_valid", 32'(cmd_valid), 1);
        check("left_dir", 32'(cmd_dir), 0);
        strobe(8'hE0);
        strobe(8'h6B);
        check("left_dup_held", 32'(held_valid), 1);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h6B);
        check("left_brk_held", 32'(held_valid), 0);
        pop_one();
        check("left_single_push", 32'(cmd_valid), 0);

        // Space make, then space break
        strobe(8'h29);
        check("space_act", 32'(activate), 1);
        check("space_nopush", 32'(cmd_valid), 0);
        @(negedge CLOCK_50);
        check("space_act_once", 32'(activate), 0);
        strobe(8'hF0);
        strobe(8'h29);
        check("space_brk_noact", 32'(activate), 0);
        check("space_brk_nopush", 32'(cmd_valid), 0);

        // Overflow: five distinct makes into a depth-4 queue
        do_reset();
        strobe(8'hE0); strobe(8'h72);
        strobe(8'hE0); strobe(8'h74);
        strobe(8'hE0); strobe(8'h72);
        strobe(8'hE0); strobe(8'h74);
        check("ovf_quiet", 32'(overflow), 0);
        strobe(8'hE0); strobe(8'h72);
        check("ovf_pulse", 32'(overflow), 1);
        @(negedge CLOCK_50);
        check("ovf_pulse_once", 32'(overflow), 0);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h72);
        check("ovf_brk_held", 32'(held_valid), 0);
        drain_expect("ovf", 2'd1, 2'd3, 2'd1, 2'd3);

        // Full queue with a pop on the fifth push: accepted, no overflow
        do_reset();
        strobe(8'hE0); strobe(8'h72);
        strobe(8'hE0); strobe(8'h74);
        strobe(8'hE0); strobe(8'h72);
        strobe(8'hE0); strobe(8'h74);
        strobe(8'hE0);
        cmd_ready = 1'b1;
        strobe(8'h72);
        cmd_ready = 1'b0;
        check("popush_noovf", 32'(overflow), 0);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h72);
        drain_expect("popush", 2'd3, 2'd1, 2'd3, 2'd1);

        // Held right arrow with the queue drained every cycle
        do_reset();
        cmd_ready = 1'b1;
        strobe(8'hE0);
        strobe(8'h74);
        for (int k = 1; k <= 19; k++) begin
            logic exp_v;
`ifdef PS2_KEY_REPEAT_EN
            exp_v = (k == 1 || k == 10 || k == 14 || k == 18);
`else
            exp_v = (k == 1);
`endif
            check($sformatf("hold_valid_k%0d", k), 32'(cmd_valid), 32'(exp_v));
            if (exp_v) begin
                check($sformatf("hold_dir_k%0d", k), 32'(cmd_dir), 3);
            end
            @(negedge CLOCK_50);
        end
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h74);
        check("hold_brk_held", 32'(held_valid), 0);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("hold_after_brk_%0d", k), 32'(cmd_valid), 0);
            @(negedge CLOCK_50);
        end
        cmd_ready = 1'b0;

        // Reset between E0 and 75 leaves the FSM idle
        do_reset();
        strobe(8'hE0);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        strobe(8'h75);
        check("rstmid_nopush", 32'(cmd_valid), 0);
        check("rstmid_noheld", 32'(held_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
